// File: rtl/operation_i_param.sv
// Iterative accumulator: loads a seed and a count from selected input channels,
// then adds INC once per clock for count cycles, with wrap or saturate overflow.
module operation_i_param #(
  parameter int unsigned     BW  = 16,
  parameter longint unsigned INC = 2,
  parameter int unsigned     NIN = 2,
  parameter int unsigned     SI  = 0,
  parameter int unsigned     CI  = 1,
  parameter int unsigned     SAT = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ST,
  input  logic [NIN*BW-1:0] IN,
  output logic              RD,
  output logic [BW-1:0]     RES,
  output logic              OVF
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [BW-1:0] INC_W = BW'(INC);
  localparam logic [BW-1:0] ONE   = 1;

  state_t            state, state_nx;
  logic [BW-1:0]     acc, acc_nx;
  logic [BW-1:0]     cnt, cnt_nx;
  logic              ovf, ovf_nx;
  logic [BW:0]       sum;
  logic [BW-1:0]     seed, count;
  logic              unused_in;

  assign seed      = IN[SI*BW +: BW];
  assign count     = IN[CI*BW +: BW];
  // Channels other than seed/count are don't-care; fold them into a sink.
  assign unused_in = ^IN;

  // One extra bit so the carry out is the overflow flag.
  assign sum = {1'b0, acc} + {1'b0, INC_W};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    case (state)
      IDLE: begin
        if (ST) begin
          acc_nx   = seed;
          cnt_nx   = count;
          ovf_nx   = 1'b0;
          state_nx = RUN;
        end
      end
      RUN: begin
        // Dropping ST aborts with the partial result left in place.
        if (!ST) begin
          state_nx = IDLE;
        end else if (cnt != '0) begin
          cnt_nx = cnt - ONE;
          if (sum[BW]) begin
            ovf_nx = 1'b1;
            acc_nx = (SAT != 0) ? '1 : sum[BW-1:0];
          end else begin
            acc_nx = sum[BW-1:0];
          end
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!ST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign RD  = (state == DONE);
  assign RES = acc;
  assign OVF = ovf;

endmodule

// File: tb/tb_operation_i_param.sv
// Randomized self-checking bench for operation_i_param across four configurations
// (wrap, saturate, 4-channel with INC=7, and 8-bit for the full-count case).
module tb_operation_i_param;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  st;
  logic [31:0] in0, in1;
  logic [63:0] in2;
  logic [15:0] in3;
  logic [3:0]  rd, ovf;
  logic [15:0] res0, res1, res2;
  logic [7:0]  res3;

  always #5 CLK = ~CLK;

  operation_i_param #(.BW(16), .INC(2), .NIN(2), .SI(0), .CI(1), .SAT(0)) d0 (
    .CLK(CLK), .RST(RST), .ST(st[0]), .IN(in0), .RD(rd[0]), .RES(res0), .OVF(ovf[0]));
  operation_i_param #(.BW(16), .INC(2), .NIN(2), .SI(0), .CI(1), .SAT(1)) d1 (
    .CLK(CLK), .RST(RST), .ST(st[1]), .IN(in1), .RD(rd[1]), .RES(res1), .OVF(ovf[1]));
  operation_i_param #(.BW(16), .INC(7), .NIN(4), .SI(2), .CI(3), .SAT(0)) d2 (
    .CLK(CLK), .RST(RST), .ST(st[2]), .IN(in2), .RD(rd[2]), .RES(res2), .OVF(ovf[2]));
  operation_i_param #(.BW(8), .INC(1), .NIN(2), .SI(0), .CI(1), .SAT(0)) d3 (
    .CLK(CLK), .RST(RST), .ST(st[3]), .IN(in3), .RD(rd[3]), .RES(res3), .OVF(ovf[3]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] res_of(input int s);
    case (s)
      0:       return res0;
      1:       return res1;
      2:       return res2;
      default: return {8'h00, res3};
    endcase
  endfunction

  // Result is seed + n*INC; any crossing of 2^BW sets the sticky flag.
  function automatic void model(input int s, input longint seed, input longint n,
                                output longint r, output bit o);
    longint bw, inc, m, t;
    bit     sat;
    bw  = (s == 3) ? 8 : 16;
    inc = (s == 2) ? 7 : (s == 3) ? 1 : 2;
    sat = (s == 1);
    m   = longint'(1) << bw;
    t   = seed + n * inc;
    o   = (t >= m);
    r   = o ? (sat ? m - 1 : t % m) : t;
  endfunction

  task automatic set_in(input int s, input logic [15:0] seed, input logic [15:0] n);
    case (s)
      0:       in0 = {n, seed};
      1:       in1 = {n, seed};
      2:       in2 = {n, seed, $urandom()};
      default: in3 = {n[7:0], seed[7:0]};
    endcase
  endtask

  task automatic scramble_in(input int s);
    case (s)
      0:       in0 = $urandom();
      1:       in1 = $urandom();
      2:       in2 = {$urandom(), $urandom()};
      default: in3 = 16'($urandom());
    endcase
  endtask

  task automatic run_op(input int s, input logic [15:0] seed, input logic [15:0] n, input string tag);
    int          edges;
    bit          got;
    longint      er;
    bit          eo;
    logic [15:0] held;
    model(s, longint'(seed), longint'(n), er, eo);
    @(negedge CLK);
    set_in(s, seed, n);
    st[s] = 1'b1;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < int'(n) + 10) begin
      @(posedge CLK);
      #1;
      edges++;
      if (rd[s]) got = 1'b1;
      else scramble_in(s);
    end
    chk({tag, "_lat"}, 64'(edges), 64'(int'(n) + 2));
    chk({tag, "_res"}, 64'(res_of(s)), 64'(er));
    chk({tag, "_ovf"}, 64'(ovf[s]), 64'(eo));
    held = res_of(s);
    repeat (3) begin
      @(negedge CLK);
      scramble_in(s);
    end
    @(posedge CLK);
    #1;
    chk({tag, "_hold_rd"}, 64'(rd[s]), 64'd1);
    chk({tag, "_hold_res"}, 64'(res_of(s)), 64'(held));
    @(negedge CLK);
    st[s] = 1'b0;
    @(posedge CLK);
    #1;
    chk({tag, "_rd_drop"}, 64'(rd[s]), 64'd0);
    chk({tag, "_idle_res"}, 64'(res_of(s)), 64'(held));
  endtask

  initial begin
    longint      er;
    bit          eo;
    int          s;
    logic [15:0] sd, n;
    st  = '0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    #12;
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_res0", 64'(res0), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    #3 RST = 1'b0;

    run_op(0, 16'h0000, 16'd1, "basic");
    run_op(0, 16'h1234, 16'd0, "n0");
    run_op(0, 16'hFFFE, 16'd3, "wrap");
    run_op(1, 16'hFFFE, 16'd3, "sat");
    run_op(2, 16'd10, 16'd4, "nin4");
    run_op(3, 16'h0000, 16'd255, "maxcnt");

    // Abort after 10 edges: load + 9 increments remain in acc.
    @(negedge CLK);
    set_in(0, 16'h0000, 16'd100);
    st[0] = 1'b1;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    st[0] = 1'b0;
    model(0, 0, 9, er, eo);
    repeat (5) begin
      @(posedge CLK);
      #1;
      chk("abort_rd", 64'(rd[0]), 64'd0);
    end
    chk("abort_res", 64'(res0), 64'(er));
    run_op(0, 16'h0000, 16'd100, "fresh");

    // Asynchronous reset mid-run with overflow already flagged.
    @(negedge CLK);
    set_in(0, 16'hFFF0, 16'd100);
    st[0] = 1'b1;
    repeat (20) @(posedge CLK);
    chk("pre_rst_ovf", 64'(ovf[0]), 64'd1);
    #3 RST = 1'b1;
    #1;
    chk("arst_rd", 64'(rd[0]), 64'd0);
    chk("arst_res", 64'(res0), 64'd0);
    chk("arst_ovf", 64'(ovf[0]), 64'd0);
    st[0] = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst_rd", 64'(rd[0]), 64'd0);
    run_op(0, 16'd5, 16'd2, "after_rst");

    for (int i = 0; i < 12; i++) begin
      s  = $urandom_range(0, 2);
      sd = 16'($urandom());
      if ($urandom_range(0, 1) == 1) sd = 16'hFF00 | sd;
      n  = 16'($urandom_range(0, 60));
      run_op(s, sd, n, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
